// File: rtl/layer_sched.sv
// -----------------------------------------------------------------------------
// layer_sched -- layer sequencer for the ConvAcc EPU.
//
// On an accepted start_i the block walks a list of 4-word layer descriptors in
// param memory (layer L at word addresses 4L+0..3). For each layer it fetches
// the descriptor, presents the one-hot EPU mode and three config words, pulses
// epu_start_o (except for idle-mode layers) and waits for epu_fin_i. finish_o
// rises after the layer carrying the last flag, or after MAX_LAYERS layers
// with err_o set.
//
// Descriptor word 0: [1:0] mode (0 idle, 1 conv3x3, 2 conv1x1, 3 maxpool),
//                    [31] last-layer flag. Words 1..3 drive epu_cfg0..2.
//
// Optional feature macro: SCHED_WDOG_EN
//   defined   -> per-layer BUSY watchdog of WDOG_W bits; after WDOG_LIMIT BUSY
//                cycles without epu_fin_i the run aborts with err_o=1.
//   undefined -> BUSY waits indefinitely.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start_i         run request, honoured only in IDLE/DONE
//   finish_o        run complete (level, held until next start or reset)
//   busy_o          high in every state except IDLE and DONE
//   err_o           sticky error (layer cap or watchdog)
//   layer_idx_o     index of the layer being processed
//   param_cs_o      param memory read enable
//   param_addr_o    param memory word address (0 when param_cs_o=0)
//   param_rdata_i   param read data, one cycle after param_cs_o
//   epu_mode_o      one-hot EPU mode
//   epu_cfg0..2_o   descriptor words 1..3
//   epu_start_o     one-cycle EPU launch pulse
//   epu_fin_i       EPU layer done (level or pulse), honoured only in BUSY
// -----------------------------------------------------------------------------

`ifndef IDLE_MODE
  `define IDLE_MODE 0
`endif
`ifndef CONV_3x3_MODE
  `define CONV_3x3_MODE 1
`endif
`ifndef CONV_1x1_MODE
  `define CONV_1x1_MODE 2
`endif
`ifndef MAX_POOL_MODE
  `define MAX_POOL_MODE 3
`endif

module layer_sched #(
  parameter int PARAM_AW   = 8,
  parameter int MAX_LAYERS = 16,
  parameter int WDOG_W     = 32,
  parameter int WDOG_LIMIT = 300000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  output logic                          finish_o,
  output logic                          busy_o,
  output logic                          err_o,
  output logic [$clog2(MAX_LAYERS)-1:0] layer_idx_o,
  output logic                          param_cs_o,
  output logic [PARAM_AW-1:0]           param_addr_o,
  input  logic [31:0]                   param_rdata_i,
  output logic [3:0]                    epu_mode_o,
  output logic [31:0]                   epu_cfg0_o,
  output logic [31:0]                   epu_cfg1_o,
  output logic [31:0]                   epu_cfg2_o,
  output logic                          epu_start_o,
  input  logic                          epu_fin_i
);

  localparam int LIDX_W = $clog2(MAX_LAYERS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_BUSY,
    S_NEXT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  fcnt_q;        // FETCH cycle 0..4 (reads in 0..3, data in 1..4)
  logic [1:0]  mode_q;        // staged descriptor fields
  logic        last_q;
  logic [31:0] w1_q, w2_q;
  logic        start_ok;
  logic        wdog_timeout;

  function automatic logic [3:0] mode_onehot(input logic [1:0] m);
    logic [3:0] oh;
    oh = '0;
    case (m)
      2'd0: oh[`IDLE_MODE]     = 1'b1;
      2'd1: oh[`CONV_3x3_MODE] = 1'b1;
      2'd2: oh[`CONV_1x1_MODE] = 1'b1;
      default: oh[`MAX_POOL_MODE] = 1'b1;
    endcase
    return oh;
  endfunction

  assign start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Optional BUSY watchdog
  // ---------------------------------------------------------------------------
`ifdef SCHED_WDOG_EN
  logic [WDOG_W-1:0] wdog_q;

  // Cleared in LAUNCH so it reads 0 in the first BUSY cycle; the value in BUSY
  // is therefore the number of BUSY cycles already elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      wdog_q <= '0;
    end else if (state_q == S_BUSY) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign wdog_timeout = (wdog_q == WDOG_W'(WDOG_LIMIT - 1));
`else
  // Watchdog compiled out: this constant-false term can never fire.
  assign wdog_timeout = (WDOG_W < 1) || (WDOG_LIMIT < 0);
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state and combinational outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    param_cs_o   = 1'b0;
    param_addr_o = '0;
    epu_start_o  = 1'b0;
    busy_o       = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_o = 1'b0;
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fcnt_q < 3'd4) begin
          param_cs_o   = 1'b1;
          param_addr_o = PARAM_AW'({layer_idx_o, fcnt_q[1:0]});
        end
        if (fcnt_q == 3'd4) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (mode_q == 2'd0) begin
          state_d = S_NEXT;          // idle layer: nothing to launch
        end else begin
          epu_start_o = 1'b1;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        // A finish coinciding with the timeout counts as normal completion.
        if (epu_fin_i)         state_d = S_NEXT;
        else if (wdog_timeout) state_d = S_DONE;
      end
      S_NEXT: begin
        if (last_q || layer_idx_o == LIDX_W'(MAX_LAYERS - 1)) state_d = S_DONE;
        else                                                  state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers and EPU-facing outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q      <= '0;
      layer_idx_o <= '0;
      finish_o    <= 1'b0;
      err_o       <= 1'b0;
      epu_mode_o  <= mode_onehot(2'd0);
      epu_cfg0_o  <= '0;
      epu_cfg1_o  <= '0;
      epu_cfg2_o  <= '0;
    end else begin
      fcnt_q <= (state_q == S_FETCH) ? fcnt_q + 3'd1 : 3'd0;

      if (start_ok) begin
        finish_o    <= 1'b0;
        err_o       <= 1'b0;
        layer_idx_o <= '0;
      end

      // Outputs change only on the edge into LAUNCH and then hold until the
      // next LAUNCH, even while the following descriptor is being staged.
      if (state_q == S_FETCH && fcnt_q == 3'd4) begin
        epu_mode_o <= mode_onehot(mode_q);
        epu_cfg0_o <= w1_q;
        epu_cfg1_o <= w2_q;
        epu_cfg2_o <= param_rdata_i;
      end

      if (state_q == S_BUSY && !epu_fin_i && wdog_timeout) begin
        err_o    <= 1'b1;
        finish_o <= 1'b1;
      end

      if (state_q == S_NEXT) begin
        if (last_q) begin
          finish_o <= 1'b1;
        end else if (layer_idx_o == LIDX_W'(MAX_LAYERS - 1)) begin
          err_o    <= 1'b1;
          finish_o <= 1'b1;
        end else begin
          layer_idx_o <= layer_idx_o + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor staging (read data arrives one cycle after each request)
  // ---------------------------------------------------------------------------
  // NOTE: staging registers carry no reset; each is written in FETCH before
  // anything reads it, so reset would only cost routing.
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) begin
      case (fcnt_q)
        3'd1: begin
          mode_q <= param_rdata_i[1:0];
          last_q <= param_rdata_i[31];
        end
        3'd2:    w1_q <= param_rdata_i;
        3'd3:    w2_q <= param_rdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_layer_sched -- directed self-checking bench for layer_sched.
// A registered param memory model and an EPU responder (fin a fixed number of
// cycles after each launch) surround the DUT; a negedge monitor logs reads,
// launches and the finish cycle relative to the start_i cycle (cycle 0).
// -----------------------------------------------------------------------------
module tb_layer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        finish_o, busy_o, err_o;
  logic [3:0]  layer_idx_o;
  logic        param_cs_o;
  logic [7:0]  param_addr_o;
  logic [31:0] param_rdata_i;
  logic [3:0]  epu_mode_o;
  logic [31:0] epu_cfg0_o, epu_cfg1_o, epu_cfg2_o;
  logic        epu_start_o;
  logic        fin_resp, fin_manual;
  wire         epu_fin_i = fin_resp | fin_manual;

  layer_sched #(
    .PARAM_AW  (8),
    .MAX_LAYERS(16),
    .WDOG_W    (32),
    .WDOG_LIMIT(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .finish_o     (finish_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .layer_idx_o  (layer_idx_o),
    .param_cs_o   (param_cs_o),
    .param_addr_o (param_addr_o),
    .param_rdata_i(param_rdata_i),
    .epu_mode_o   (epu_mode_o),
    .epu_cfg0_o   (epu_cfg0_o),
    .epu_cfg1_o   (epu_cfg1_o),
    .epu_cfg2_o   (epu_cfg2_o),
    .epu_start_o  (epu_start_o),
    .epu_fin_i    (epu_fin_i)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- param memory model ----------------
  logic [31:0] mem [256];

  always @(posedge clk)
    param_rdata_i <= param_cs_o ? mem[param_addr_o] : 32'hDEAD_BEEF;

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic set_desc(input int l, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    mem[4*l+0] = w0;
    mem[4*l+1] = w1;
    mem[4*l+2] = w2;
    mem[4*l+3] = w3;
  endtask

  // ---------------- monitor + EPU responder ----------------
  int          cyc = 0;
  int          t0  = 0;
  int          rel_now;
  int          fin_delay = 10;
  bit          fin_en = 1'b1;
  int          fin_cd = 0;
  int          first_launch_rel;
  int          finish_rel;
  int          addr_viol;
  logic [7:0]  addr_q [$];
  int          addr_rel_q [$];
  logic [3:0]  idx_q [$];
  logic [3:0]  lmode_q [$];
  logic [31:0] lcfg_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_logs();
    addr_q.delete();
    addr_rel_q.delete();
    idx_q.delete();
    lmode_q.delete();
    lcfg_q.delete();
    first_launch_rel = -1;
    finish_rel       = -1;
    addr_viol        = 0;
  endtask

  always @(negedge clk) begin
    rel_now  = cyc - t0;
    fin_resp = 1'b0;
    if (rst) begin
      fin_cd = 0;
    end else begin
      if (param_cs_o) begin
        addr_q.push_back(param_addr_o);
        addr_rel_q.push_back(rel_now);
        if (param_addr_o[1:0] == 2'd0) idx_q.push_back(layer_idx_o);
      end else if (param_addr_o != 8'd0) begin
        addr_viol++;
      end
      if (epu_start_o) begin
        lmode_q.push_back(epu_mode_o);
        lcfg_q.push_back(epu_cfg2_o);
        if (first_launch_rel < 0) first_launch_rel = rel_now;
      end
      if (finish_o && finish_rel < 0 && rel_now > 0) finish_rel = rel_now;
      if (fin_cd > 0) begin
        fin_cd--;
        if (fin_cd == 0) fin_resp = 1'b1;
      end
      if (epu_start_o && fin_en) fin_cd = fin_delay;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Cycle 0 is the cycle in which start_i is high; returns at negedge of cycle 1.
  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    t0      = cyc;
    clear_logs();
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int budget);
    for (int i = 0; i < budget && !finish_o; i++) @(negedge clk);
    check({tag, "_finish"}, finish_o, 1'b1);
  endtask

  // Checks shared by scenario 2 and scenario 5 (identical expected sequence).
  task automatic check_single_layer(input string tag);
    check({tag, "_nreads"}, addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_addr%0d", tag, i), addr_q[i], i);
      check($sformatf("%s_addr%0d_cyc", tag, i), addr_rel_q[i], i + 1);
    end
    check({tag, "_nlaunch"}, lmode_q.size(), 1);
    check({tag, "_launch_cyc"}, first_launch_rel, 6);
    check({tag, "_mode"}, lmode_q[0], 4'b0010);
    check({tag, "_cfg0"}, epu_cfg0_o, 32'h1111_0001);
    check({tag, "_cfg1"}, epu_cfg1_o, 32'h2222_0002);
    check({tag, "_cfg2"}, epu_cfg2_o, 32'h3333_0003);
    check({tag, "_finish_cyc"}, finish_rel, 18);  // fin in cycle 16 -> +2
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_busy_done"}, busy_o, 1'b0);
    check({tag, "_addr_zero"}, addr_viol, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    fin_manual = 1'b0;
    fin_resp   = 1'b0;
    clear_mem();
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_finish", finish_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_mode", epu_mode_o, 4'b0001);
    check("rst_idx", layer_idx_o, 4'd0);
    check("rst_cs", param_cs_o, 1'b0);
    check("rst_addr", param_addr_o, 8'd0);
    check("rst_start", epu_start_o, 1'b0);
    check("rst_cfg0", epu_cfg0_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- Scenario 2: single conv3x3 layer, fin 10 cycles after launch ----
    set_desc(0, 32'h8000_0001, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003);
    fin_delay = 10;
    do_start();
    check("s2_finish_clr", finish_o, 1'b0);
    wait_finish("s2", 200);
    @(negedge clk);
    check_single_layer("s2");

    // ---- Scenario 5: start_i in BUSY, epu_fin_i in FETCH and LAUNCH ignored ----
    do_start();                                  // now in cycle 1
    @(negedge clk); fin_manual = 1'b1;           // cycle 2 (FETCH)
    @(negedge clk); fin_manual = 1'b0;           // cycle 3
    repeat (3) @(negedge clk); fin_manual = 1'b1; // cycle 6 (LAUNCH)
    @(negedge clk); fin_manual = 1'b0;           // cycle 7
    repeat (3) @(negedge clk); start_i = 1'b1;   // cycle 10 (BUSY)
    @(negedge clk); start_i = 1'b0;              // cycle 11
    wait_finish("s5", 200);
    @(negedge clk);
    check_single_layer("s5");

    // ---- Scenario 3: conv1x1, idle, maxpool+last ----
    clear_mem();
    set_desc(0, 32'h0000_0002, 32'hA0, 32'hA1, 32'hA2);
    set_desc(1, 32'h7FFF_FFFC, 32'hB0, 32'hB1, 32'hB2);  // mode 0, no last flag
    set_desc(2, 32'h8000_0003, 32'hC0, 32'hC1, 32'hC2);
    fin_delay = 3;
    do_start();
    wait_finish("s3", 300);
    check("s3_nreads", addr_q.size(), 12);
    for (int i = 0; i < 12; i++) check($sformatf("s3_addr%0d", i), addr_q[i], i);
    check("s3_nlaunch", lmode_q.size(), 2);
    check("s3_mode0", lmode_q[0], 4'b0100);
    check("s3_mode1", lmode_q[1], 4'b1000);
    check("s3_cfg2_l0", lcfg_q[0], 32'hA2);
    check("s3_cfg2_l2", lcfg_q[1], 32'hC2);
    check("s3_nidx", idx_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("s3_idx%0d", i), idx_q[i], i);
    check("s3_err", err_o, 1'b0);
    check("s3_addr_zero", addr_viol, 0);

    // ---- Scenario 4: 16 layers, no last flag -> cap error ----
    clear_mem();
    for (int l = 0; l < 17; l++) set_desc(l, 32'h0000_0001, l, l + 100, l + 200);
    fin_delay = 2;
    do_start();
    wait_finish("s4", 2000);
    check("s4_nlaunch", lmode_q.size(), 16);
    check("s4_nreads", addr_q.size(), 64);
    check("s4_last_addr", addr_q[addr_q.size()-1], 8'd63);
    check("s4_err", err_o, 1'b1);
    check("s4_idx", layer_idx_o, 4'd15);
    check("s4_cfg2", epu_cfg2_o, 32'd215);
    check("s4_addr_zero", addr_viol, 0);
    @(negedge clk);
    check("s4_finish_hold", finish_o, 1'b1);

    // ---- Scenario 1: reset mid-BUSY ----
    clear_mem();
    set_desc(0, 32'h8000_0001, 32'h55, 32'h66, 32'h77);
    fin_en = 1'b0;
    do_start();
    for (int i = 0; i < 20 && first_launch_rel < 0; i++) @(negedge clk);
    check("s1_launched", first_launch_rel, 6);
`ifdef SCHED_WDOG_EN
    repeat (10) @(negedge clk);
`else
    repeat (40) @(negedge clk);
    check("s1_no_wdog_err", err_o, 1'b0);
`endif
    check("s1_busy_before", busy_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("s1_busy", busy_o, 1'b0);
    check("s1_finish", finish_o, 1'b0);
    check("s1_mode", epu_mode_o, 4'b0001);
    check("s1_cfg0", epu_cfg0_o, 32'd0);
    check("s1_idx", layer_idx_o, 4'd0);
    rst = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    check("s1_no_reads", addr_q.size(), 0);
    check("s1_no_launch", lmode_q.size(), 0);
    check("s1_still_idle", busy_o, 1'b0);
    fin_en = 1'b1;

`ifdef SCHED_WDOG_EN
    // ---- Scenario 6: watchdog with WDOG_LIMIT=20, no epu_fin_i ----
    clear_mem();
    set_desc(0, 32'h0000_0001, 32'h1, 32'h2, 32'h3);
    set_desc(1, 32'h8000_0001, 32'h4, 32'h5, 32'h6);
    fin_en = 1'b0;
    do_start();
    wait_finish("s6", 200);
    check("s6_err", err_o, 1'b1);
    check("s6_finish_cyc", finish_rel, 27);       // BUSY cycles 7..26
    check("s6_nlaunch", lmode_q.size(), 1);
    check("s6_nreads", addr_q.size(), 4);
    fin_en    = 1'b1;
    fin_delay = 4;
    do_start();
    check("s6_err_clr", err_o, 1'b0);
    check("s6_finish_clr", finish_o, 1'b0);
    wait_finish("s6b", 300);
    check("s6b_first_addr", addr_q[0], 8'd0);
    check("s6b_nlaunch", lmode_q.size(), 2);
    check("s6b_err", err_o, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

endmodule
